// File: rtl/debounce_event_counter_amisha.sv
// rtl/debounce_event_counter_amisha.sv - multi-channel switch debounce with raw/debounced edge counters
// Per-channel 3-flop sync, 4-state debounce FSM, wrap/saturate counters, registered readout.
module debounce_event_counter_amisha #(
  parameter int N_CH      = 2,
  parameter int CNT_W     = 8,
  parameter int DB_CYCLES = 1000000,
  parameter bit SAT       = 1'b0,
  localparam int SEL_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk_amisha,
  input  logic             reset_amisha,
  input  logic [N_CH-1:0]  sw_amisha,
  input  logic [N_CH-1:0]  clr_amisha,
  input  logic [SEL_W-1:0] sel_amisha,
  output logic [N_CH-1:0]  db_level_amisha,
  output logic [N_CH-1:0]  db_tick_amisha,
  output logic [N_CH-1:0]  ovf_amisha,
  output logic [CNT_W-1:0] raw_cnt_amisha,
  output logic [CNT_W-1:0] db_cnt_amisha
);

  localparam int TW = $clog2(DB_CYCLES);
  localparam logic [TW-1:0] TLOAD = TW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {ZERO, WAIT1, ONE, WAIT0} state_t;

  logic [N_CH-1:0]  r_s1, r_s2, r_s3;
  state_t           r_state     [N_CH];
  state_t           w_state_nxt [N_CH];
  logic [TW-1:0]    r_timer     [N_CH];
  logic [TW-1:0]    w_timer_nxt [N_CH];
  logic [N_CH-1:0]  w_raw_tick, w_db_tick, w_db_level;
  logic [CNT_W-1:0] r_raw_cnt   [N_CH];
  logic [CNT_W-1:0] r_db_cnt    [N_CH];
  logic [N_CH-1:0]  r_ovf;
  logic [CNT_W-1:0] w_raw_sel, w_db_sel;
  logic [CNT_W-1:0] r_raw_out, r_db_out;

  always_ff @(posedge clk_amisha) begin
    if (!reset_amisha) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_s3 <= '0;
    end else begin
      r_s1 <= sw_amisha;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_raw_tick = r_s2 & ~r_s3;

  always_ff @(posedge clk_amisha) begin
    for (int c = 0; c < N_CH; c++) begin
      if (!reset_amisha) begin
        r_state[c] <= ZERO;
        r_timer[c] <= '0;
      end else begin
        r_state[c] <= w_state_nxt[c];
        r_timer[c] <= w_timer_nxt[c];
      end
    end
  end

  // Tick is Mealy: raised in the last WAIT1 cycle so it lines up with the count update.
  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      w_state_nxt[c] = r_state[c];
      w_timer_nxt[c] = r_timer[c];
      w_db_tick[c]   = 1'b0;
      w_db_level[c]  = 1'b0;
      case (r_state[c])
        ZERO: begin
          if (r_s2[c]) begin
            w_state_nxt[c] = WAIT1;
            w_timer_nxt[c] = TLOAD;
          end
        end
        WAIT1: begin
          if (!r_s2[c]) begin
            w_state_nxt[c] = ZERO;
          end else if (r_timer[c] == '0) begin
            w_state_nxt[c] = ONE;
            w_db_tick[c]   = 1'b1;
          end else begin
            w_timer_nxt[c] = r_timer[c] - TW'(1);
          end
        end
        ONE: begin
          w_db_level[c] = 1'b1;
          if (!r_s2[c]) begin
            w_state_nxt[c] = WAIT0;
            w_timer_nxt[c] = TLOAD;
          end
        end
        WAIT0: begin
          w_db_level[c] = 1'b1;
          if (r_s2[c]) begin
            w_state_nxt[c] = ONE;
          end else if (r_timer[c] == '0) begin
            w_state_nxt[c] = ZERO;
          end else begin
            w_timer_nxt[c] = r_timer[c] - TW'(1);
          end
        end
        default: begin
          w_state_nxt[c] = ZERO;
        end
      endcase
    end
  end

  always_ff @(posedge clk_amisha) begin
    for (int c = 0; c < N_CH; c++) begin
      if (!reset_amisha) begin
        r_raw_cnt[c] <= '0;
        r_db_cnt[c]  <= '0;
        r_ovf[c]     <= 1'b0;
      end else if (clr_amisha[c]) begin
        r_raw_cnt[c] <= '0;
        r_db_cnt[c]  <= '0;
        r_ovf[c]     <= 1'b0;
      end else begin
        if (w_raw_tick[c]) begin
          if (&r_raw_cnt[c]) begin
            r_ovf[c] <= 1'b1;
            if (!SAT) r_raw_cnt[c] <= '0;
          end else begin
            r_raw_cnt[c] <= r_raw_cnt[c] + CNT_W'(1);
          end
        end
        if (w_db_tick[c]) begin
          if (&r_db_cnt[c]) begin
            r_ovf[c] <= 1'b1;
            if (!SAT) r_db_cnt[c] <= '0;
          end else begin
            r_db_cnt[c] <= r_db_cnt[c] + CNT_W'(1);
          end
        end
      end
    end
  end

  // Out-of-range selects match no channel and read as zero.
  always_comb begin
    w_raw_sel = '0;
    w_db_sel  = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (sel_amisha == SEL_W'(c)) begin
        w_raw_sel = r_raw_cnt[c];
        w_db_sel  = r_db_cnt[c];
      end
    end
  end

  always_ff @(posedge clk_amisha) begin
    if (!reset_amisha) begin
      r_raw_out <= '0;
      r_db_out  <= '0;
    end else begin
      r_raw_out <= w_raw_sel;
      r_db_out  <= w_db_sel;
    end
  end

  assign db_level_amisha = w_db_level;
  assign db_tick_amisha  = w_db_tick;
  assign ovf_amisha      = r_ovf;
  assign raw_cnt_amisha  = r_raw_out;
  assign db_cnt_amisha   = r_db_out;

endmodule
